// File: rtl/e603_tcm_burst_split.sv
// Splits upstream ICB read bursts into single-beat SRAM-controller commands.
// Single-beat commands pass straight through; responses are forwarded unbuffered.
module e603_tcm_burst_split #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int MW    = 4,
    parameter int USR_W = 3,
    parameter int LEN_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               icb_cmd_valid,
    output logic               icb_cmd_ready,
    input  logic               icb_cmd_read,
    input  logic [AW-1:0]      icb_cmd_addr,
    input  logic [DW-1:0]      icb_cmd_wdata,
    input  logic [MW-1:0]      icb_cmd_wmask,
    input  logic [1:0]         icb_cmd_size,
    input  logic [LEN_W-1:0]   icb_cmd_len,
    input  logic               icb_cmd_wrap,
    input  logic [USR_W-1:0]   icb_cmd_usr,
    output logic               icb_rsp_valid,
    input  logic               icb_rsp_ready,
    output logic [DW-1:0]      icb_rsp_rdata,
    output logic               icb_rsp_err,
    output logic               icb_rsp_last,
    output logic [USR_W-1:0]   icb_rsp_usr,
    output logic               uop_cmd_valid,
    input  logic               uop_cmd_ready,
    output logic               uop_cmd_read,
    output logic [AW-1:0]      uop_cmd_addr,
    output logic [DW-1:0]      uop_cmd_wdata,
    output logic [MW-1:0]      uop_cmd_wmask,
    output logic [1:0]         uop_cmd_size,
    output logic [USR_W+1:0]   uop_cmd_usr,
    input  logic               uop_rsp_valid,
    output logic               uop_rsp_ready,
    input  logic [DW-1:0]      uop_rsp_rdata,
    input  logic               uop_rsp_err,
    input  logic [USR_W+1:0]   uop_rsp_usr,
    output logic               split_active
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [AW-1:0]    ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       MAX_SIZE = 2'($clog2(MW));

    state_t             r_state;
    logic [AW-1:0]      r_addr;
    logic [1:0]         r_size;
    logic [LEN_W-1:0]   r_len;
    logic               r_wrap;
    logic [USR_W-1:0]   r_usr;
    logic [LEN_W-1:0]   r_cnt;

    logic               w_err_idle;
    logic               w_last_idle;
    logic               w_start_burst;

    // Wrap only applies when the beat count is a power of two; otherwise increment.
    function automatic logic [AW-1:0] next_addr(
        input logic [AW-1:0]    addr,
        input logic [1:0]       size,
        input logic [LEN_W-1:0] len,
        input logic             wrap
    );
        logic [LEN_W:0]  beats;
        logic [AW-1:0]   inc;
        logic [AW-1:0]   win_mask;
        beats    = {1'b0, len} + {{LEN_W{1'b0}}, 1'b1};
        inc      = addr + (ADDR_ONE << size);
        win_mask = ({{(AW-LEN_W-1){1'b0}}, beats} << size) - ADDR_ONE;
        if (wrap && ((beats & (beats - {{LEN_W{1'b0}}, 1'b1})) == {(LEN_W+1){1'b0}})) begin
            next_addr = (addr & ~win_mask) | (inc & win_mask);
        end else begin
            next_addr = inc;
        end
    endfunction

    // Command-side decode and output mux for the current state.
    always_comb begin
        w_err_idle    = ((!icb_cmd_read) && (icb_cmd_len != LEN_ZERO)) || (icb_cmd_size > MAX_SIZE);
        w_last_idle   = (icb_cmd_len == LEN_ZERO) || (!icb_cmd_read);
        w_start_burst = icb_cmd_valid && uop_cmd_ready && icb_cmd_read && (icb_cmd_len != LEN_ZERO);
        icb_cmd_ready = 1'b0;
        uop_cmd_valid = 1'b0;
        uop_cmd_read  = 1'b0;
        uop_cmd_addr  = {AW{1'b0}};
        uop_cmd_wdata = {DW{1'b0}};
        uop_cmd_wmask = {MW{1'b0}};
        uop_cmd_size  = 2'b00;
        uop_cmd_usr   = {(USR_W+2){1'b0}};
        case (r_state)
            ST_IDLE: begin
                icb_cmd_ready = uop_cmd_ready;
                uop_cmd_valid = icb_cmd_valid;
                uop_cmd_read  = icb_cmd_read;
                uop_cmd_addr  = icb_cmd_addr;
                uop_cmd_wdata = icb_cmd_wdata;
                uop_cmd_wmask = icb_cmd_wmask;
                uop_cmd_size  = icb_cmd_size;
                uop_cmd_usr   = {w_err_idle, w_last_idle, icb_cmd_usr};
            end
            ST_BURST: begin
                uop_cmd_valid = 1'b1;
                uop_cmd_read  = 1'b1;
                uop_cmd_addr  = r_addr;
                uop_cmd_size  = r_size;
                uop_cmd_usr   = {(r_size > MAX_SIZE), (r_cnt == r_len), r_usr};
            end
            default: begin
                icb_cmd_ready = 1'b0;
                uop_cmd_valid = 1'b0;
            end
        endcase
    end

    // Response pass-through; err/last ride along in the downstream tag.
    always_comb begin
        icb_rsp_valid = uop_rsp_valid;
        uop_rsp_ready = icb_rsp_ready;
        icb_rsp_rdata = uop_rsp_rdata;
        icb_rsp_err   = uop_rsp_err | uop_rsp_usr[USR_W+1];
        icb_rsp_last  = uop_rsp_usr[USR_W];
        icb_rsp_usr   = uop_rsp_usr[USR_W-1:0];
        split_active  = (r_state == ST_BURST) | icb_cmd_valid | uop_rsp_valid;
    end

    // Burst sequencer: beat 0 leaves from IDLE, remaining beats from the latched context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= {AW{1'b0}};
            r_size  <= 2'b00;
            r_len   <= LEN_ZERO;
            r_wrap  <= 1'b0;
            r_usr   <= {USR_W{1'b0}};
            r_cnt   <= LEN_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_burst) begin
                        r_state <= ST_BURST;
                        r_addr  <= next_addr(icb_cmd_addr, icb_cmd_size, icb_cmd_len, icb_cmd_wrap);
                        r_size  <= icb_cmd_size;
                        r_len   <= icb_cmd_len;
                        r_wrap  <= icb_cmd_wrap;
                        r_usr   <= icb_cmd_usr;
                        r_cnt   <= LEN_ONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (uop_cmd_ready) begin
                        r_addr <= next_addr(r_addr, r_size, r_len, r_wrap);
                        if (r_cnt == r_len) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= LEN_ZERO;
                        end else begin
                            r_cnt   <= r_cnt + LEN_ONE;
                        end
                    end else begin
                        r_state <= ST_BURST;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= LEN_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e603_tcm_burst_split.sv
// Directed self-checking bench for e603_tcm_burst_split.
module tb_e603_tcm_burst_split;

    logic        clk;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_addr;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic [1:0]  icb_cmd_size;
    logic [2:0]  icb_cmd_len;
    logic        icb_cmd_wrap;
    logic [2:0]  icb_cmd_usr;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        icb_rsp_last;
    logic [2:0]  icb_rsp_usr;
    logic        uop_cmd_valid;
    logic        uop_cmd_ready;
    logic        uop_cmd_read;
    logic [31:0] uop_cmd_addr;
    logic [31:0] uop_cmd_wdata;
    logic [3:0]  uop_cmd_wmask;
    logic [1:0]  uop_cmd_size;
    logic [4:0]  uop_cmd_usr;
    logic        uop_rsp_valid;
    logic        uop_rsp_ready;
    logic [31:0] uop_rsp_rdata;
    logic        uop_rsp_err;
    logic [4:0]  uop_rsp_usr;
    logic        split_active;

    int checks;
    int failures;

    e603_tcm_burst_split dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_cmd_size(icb_cmd_size), .icb_cmd_len(icb_cmd_len),
        .icb_cmd_wrap(icb_cmd_wrap), .icb_cmd_usr(icb_cmd_usr),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .icb_rsp_last(icb_rsp_last), .icb_rsp_usr(icb_rsp_usr),
        .uop_cmd_valid(uop_cmd_valid), .uop_cmd_ready(uop_cmd_ready),
        .uop_cmd_read(uop_cmd_read), .uop_cmd_addr(uop_cmd_addr),
        .uop_cmd_wdata(uop_cmd_wdata), .uop_cmd_wmask(uop_cmd_wmask),
        .uop_cmd_size(uop_cmd_size), .uop_cmd_usr(uop_cmd_usr),
        .uop_rsp_valid(uop_rsp_valid), .uop_rsp_ready(uop_rsp_ready),
        .uop_rsp_rdata(uop_rsp_rdata), .uop_rsp_err(uop_rsp_err),
        .uop_rsp_usr(uop_rsp_usr), .split_active(split_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic v, input logic rd, input logic [31:0] a, input logic [1:0] sz,
                       input logic [2:0] ln, input logic wr, input logic [2:0] u);
        icb_cmd_valid = v;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_size  = sz;
        icb_cmd_len   = ln;
        icb_cmd_wrap  = wr;
        icb_cmd_usr   = u;
    endtask

    // Step to the next drive point: just after the falling edge.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [4:0] u, input logic rdy);
        #1;
        chk({tag, "_valid"}, {63'd0, uop_cmd_valid}, 64'd1);
        chk({tag, "_addr"}, {32'd0, uop_cmd_addr}, {32'd0, a});
        chk({tag, "_usr"}, {59'd0, uop_cmd_usr}, {59'd0, u});
        chk({tag, "_icbrdy"}, {63'd0, icb_cmd_ready}, {63'd0, rdy});
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        cmd(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 3'd0);
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b1;
        uop_cmd_ready = 1'b1;
        uop_rsp_valid = 1'b0;
        uop_rsp_rdata = 32'h0;
        uop_rsp_err   = 1'b0;
        uop_rsp_usr   = 5'd0;
        nxt(); nxt();
        #1;
        chk("rst_split_active", {63'd0, split_active}, 64'd0);
        chk("rst_uop_valid", {63'd0, uop_cmd_valid}, 64'd0);
        chk("rst_icb_ready", {63'd0, icb_cmd_ready}, 64'd1);
        nxt();
        rst_n = 1'b1;

        // Incrementing read, valid held high through the burst
        nxt(); cmd(1'b1, 1'b1, 32'h100, 2'd2, 3'd3, 1'b0, 3'd5);
        beat("inc0", 32'h100, 5'b00101, 1'b1);
        chk("inc0_size", {62'd0, uop_cmd_size}, 64'd2);
        nxt(); beat("inc1", 32'h104, 5'b00101, 1'b0);
        chk("inc1_active", {63'd0, split_active}, 64'd1);
        nxt(); beat("inc2", 32'h108, 5'b00101, 1'b0);
        nxt(); beat("inc3", 32'h10C, 5'b01101, 1'b0);
        nxt(); cmd(1'b0, 1'b1, 32'h100, 2'd2, 3'd3, 1'b0, 3'd5);
        #1;
        chk("inc_done_valid", {63'd0, uop_cmd_valid}, 64'd0);
        chk("inc_done_active", {63'd0, split_active}, 64'd0);

        // Wrapping read, window 16 bytes
        nxt(); cmd(1'b1, 1'b1, 32'h108, 2'd2, 3'd3, 1'b1, 3'd2);
        beat("wrp0", 32'h108, 5'b00010, 1'b1);
        nxt(); cmd(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 3'd0);
        beat("wrp1", 32'h10C, 5'b00010, 1'b0);
        chk("wrp1_wdata", {32'd0, uop_cmd_wdata}, 64'd0);
        nxt(); beat("wrp2", 32'h100, 5'b00010, 1'b0);
        nxt(); beat("wrp3", 32'h104, 5'b01010, 1'b0);

        // Wrap with 3 beats: not a power of two, so increments without error
        nxt(); cmd(1'b1, 1'b1, 32'h108, 2'd2, 3'd2, 1'b1, 3'd1);
        beat("npw0", 32'h108, 5'b00001, 1'b1);
        nxt(); cmd(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 3'd0);
        beat("npw1", 32'h10C, 5'b00001, 1'b0);
        nxt(); beat("npw2", 32'h110, 5'b01001, 1'b0);

        // Write with len!=0: one beat, error-tagged, stays IDLE
        nxt(); cmd(1'b1, 1'b0, 32'h200, 2'd2, 3'd2, 1'b0, 3'd3);
        icb_cmd_wdata = 32'hDEADBEEF;
        icb_cmd_wmask = 4'hF;
        beat("wr0", 32'h200, 5'b11011, 1'b1);
        chk("wr0_read", {63'd0, uop_cmd_read}, 64'd0);
        chk("wr0_wdata", {32'd0, uop_cmd_wdata}, 64'hDEADBEEF);
        chk("wr0_wmask", {60'd0, uop_cmd_wmask}, 64'hF);
        nxt(); cmd(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 3'd0);
        #1;
        chk("wr_idle_valid", {63'd0, uop_cmd_valid}, 64'd0);
        uop_rsp_valid = 1'b1;
        uop_rsp_usr   = 5'b11011;
        uop_rsp_rdata = 32'h1234;
        #1;
        chk("wr_rsp_err", {63'd0, icb_rsp_err}, 64'd1);
        chk("wr_rsp_last", {63'd0, icb_rsp_last}, 64'd1);
        chk("wr_rsp_usr", {61'd0, icb_rsp_usr}, 64'd3);
        chk("wr_rsp_rdata", {32'd0, icb_rsp_rdata}, 64'h1234);
        chk("wr_rsp_valid", {63'd0, icb_rsp_valid}, 64'd1);
        chk("rsp_active", {63'd0, split_active}, 64'd1);
        uop_rsp_usr = 5'b00101;
        uop_rsp_err = 1'b1;
        icb_rsp_ready = 1'b0;
        #1;
        chk("rsp2_err", {63'd0, icb_rsp_err}, 64'd1);
        chk("rsp2_last", {63'd0, icb_rsp_last}, 64'd0);
        chk("rsp2_ready", {63'd0, uop_rsp_ready}, 64'd0);
        uop_rsp_err = 1'b0;
        #1;
        chk("rsp3_err", {63'd0, icb_rsp_err}, 64'd0);
        uop_rsp_valid = 1'b0;
        icb_rsp_ready = 1'b1;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;

        // Oversized beat: error tag set, single beat
        nxt(); cmd(1'b1, 1'b1, 32'h400, 2'd3, 3'd0, 1'b0, 3'd1);
        beat("sz3", 32'h400, 5'b11001, 1'b1);

        // Downstream backpressure in the middle of a burst
        nxt(); uop_cmd_ready = 1'b0; cmd(1'b1, 1'b1, 32'h100, 2'd2, 3'd3, 1'b0, 3'd4);
        #1;
        chk("idle_bp_icbrdy", {63'd0, icb_cmd_ready}, 64'd0);
        uop_cmd_ready = 1'b1;
        beat("bp0", 32'h100, 5'b00100, 1'b1);
        nxt(); cmd(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 3'd0); uop_cmd_ready = 1'b0;
        beat("bp1a", 32'h104, 5'b00100, 1'b0);
        nxt(); beat("bp1b", 32'h104, 5'b00100, 1'b0);
        chk("bp1b_size", {62'd0, uop_cmd_size}, 64'd2);
        nxt(); uop_cmd_ready = 1'b1;
        beat("bp1c", 32'h104, 5'b00100, 1'b0);
        nxt(); beat("bp2", 32'h108, 5'b00100, 1'b0);
        nxt(); beat("bp3", 32'h10C, 5'b01100, 1'b0);
        nxt(); #1;
        chk("bp_done_valid", {63'd0, uop_cmd_valid}, 64'd0);

        // Address rollover at the top of the map
        cmd(1'b1, 1'b1, 32'hFFFFFFFC, 2'd2, 3'd1, 1'b0, 3'd6);
        beat("ovf0", 32'hFFFFFFFC, 5'b00110, 1'b1);
        nxt(); cmd(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 3'd0);
        beat("ovf1", 32'h00000000, 5'b01110, 1'b0);

        // Reset mid-burst abandons remaining beats
        nxt(); cmd(1'b1, 1'b1, 32'h300, 2'd2, 3'd7, 1'b0, 3'd7);
        beat("rb0", 32'h300, 5'b00111, 1'b1);
        nxt(); cmd(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 3'd0);
        beat("rb1", 32'h304, 5'b00111, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rb_rst_valid", {63'd0, uop_cmd_valid}, 64'd0);
        chk("rb_rst_active", {63'd0, split_active}, 64'd0);
        cmd(1'b1, 1'b1, 32'h500, 2'd2, 3'd0, 1'b0, 3'd2);
        beat("rb_pass", 32'h500, 5'b01010, 1'b1);
        nxt(); cmd(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 3'd0);
        rst_n = 1'b1;
        nxt(); #1;
        chk("rb_after_valid", {63'd0, uop_cmd_valid}, 64'd0);
        chk("rb_after_active", {63'd0, split_active}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
